// File: rtl/bram1be_requester_if.sv
// Request/response/RAM-port bundle for bram1be_requester.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready, and payload is only meaningful while valid is high.
interface bram1be_requester_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int WE_WIDTH   = 1
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WE_WIDTH-1:0]   req_be;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  bram_en;
    logic [WE_WIDTH-1:0]   bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_di;
    logic [DATA_WIDTH-1:0] bram_do;

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_data, resp_ready, bram_do,
        output req_ready, resp_valid, resp_data, bram_en, bram_we, bram_addr, bram_di
    );

    modport master (
        output req_valid, req_write, req_addr, req_be, req_data, resp_ready, bram_do,
        input  req_ready, resp_valid, resp_data, bram_en, bram_we, bram_addr, bram_di
    );
endinterface

// File: rtl/bram1be_requester.sv
// Drives a byte-enable single-port BRAM from a request stream and returns read data in order;
// a credit counter reserves a response slot for every issued read so the RAM never stalls.
module bram1be_requester #(
    parameter int PIPELINED  = 0,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int CHUNKSIZE  = 8,
    parameter int WE_WIDTH   = 1,
    parameter int RESP_DEPTH = 4
) (
    input logic CLK,
    input logic RST,
    bram1be_requester_if.slave bus
);
    localparam int LAT = 1 + PIPELINED;
    localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW  = $clog2(RESP_DEPTH) + 1;

    if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_lanes
        $error("DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
    end

    logic [CW-1:0]         cnt;
    logic [LAT-1:0]        tag;
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  resp_fire;
    logic                  capture;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Credit covers reads in flight plus queued responses, so the FIFO can never overflow.
    assign bus.req_ready = !RST && (cnt < CW'(RESP_DEPTH));
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign rd_fire       = req_fire && !bus.req_write;

    assign bus.bram_en   = req_fire;
    assign bus.bram_we   = (req_fire && bus.req_write) ? bus.req_be : '0;
    assign bus.bram_addr = bus.req_addr;
    assign bus.bram_di   = bus.req_data;

    assign capture        = tag[LAT-1];
    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_data  = fifo_mem[rd_ptr[PW-1:0]];
    assign resp_fire      = bus.resp_valid && bus.resp_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            tag    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // Tag shift tracks which RAM output cycles belong to reads.
            tag <= LAT'({tag, rd_fire});
            if (capture) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (resp_fire) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            case ({rd_fire, resp_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(capture && fifo_full));
            if (capture) begin
                fifo_mem[wr_ptr[PW-1:0]] <= bus.bram_do;
            end
        end
    end
endmodule

// File: tb/tb_bram1be_requester.sv
// Directed plus randomized bench for bram1be_requester with a behavioural BRAM and shadow-memory model.
module tb_bram1be_requester;
  localparam int PIPELINED  = 1;
  localparam int AW         = 4;
  localparam int DW         = 32;
  localparam int WE         = 4;
  localparam int CH         = 8;
  localparam int RESP_DEPTH = 4;
  localparam int LAT        = 1 + PIPELINED;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bram1be_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WE)) bus ();

  bram1be_requester #(
    .PIPELINED(PIPELINED), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CHUNKSIZE(CH), .WE_WIDTH(WE), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // response-side backpressure: manual level or random per cycle
  logic rand_mode = 1'b0;
  logic rr_manual = 1'b1;
  logic rr_rand   = 1'b1;
  always @(posedge clk) begin
    #1;
    rr_rand = ($urandom_range(0, 3) != 0);
  end
  assign bus.resp_ready = rand_mode ? rr_rand : rr_manual;

  // behavioural byte-enable RAM, read-first, optional output register
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] do1;
  logic [DW-1:0] do2;
  always @(posedge clk) begin
    if (bus.bram_en) begin
      for (int l = 0; l < WE; l++)
        if (bus.bram_we[l]) ram[bus.bram_addr][l*CH +: CH] <= bus.bram_di[l*CH +: CH];
      do1 <= ram[bus.bram_addr];
    end
    do2 <= do1;
  end
  assign bus.bram_do = (PIPELINED != 0) ? do2 : do1;

  // reference model: shadow memory, expected response data and accept cycle
  logic [DW-1:0] shadow [1<<AW];
  logic [DW-1:0] exp_q[$];
  int            exp_t[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic exp_fire;
  logic exp_rv;
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_rst", DW'(bus.req_ready), DW'(0));
      chk("en_in_rst", DW'(bus.bram_en), DW'(0));
      exp_q.delete();
      exp_t.delete();
    end else begin
      exp_fire = bus.req_valid && (exp_q.size() < RESP_DEPTH);
      chk("req_ready", DW'(bus.req_ready), DW'(exp_q.size() < RESP_DEPTH));
      chk("bram_en", DW'(bus.bram_en), DW'(exp_fire));
      chk("bram_we", DW'(bus.bram_we), (exp_fire && bus.req_write) ? DW'(bus.req_be) : DW'(0));
      if (exp_fire) begin
        chk("bram_addr", DW'(bus.bram_addr), DW'(bus.req_addr));
        chk("bram_di", bus.bram_di, bus.req_data);
      end
      exp_rv = (exp_q.size() > 0) && (cyc >= exp_t[0] + LAT + 1);
      chk("resp_valid", DW'(bus.resp_valid), DW'(exp_rv));
      if (bus.resp_valid && bus.resp_ready && exp_q.size() > 0) begin
        chk("resp_data", bus.resp_data, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
      end
      if (exp_fire) begin
        if (bus.req_write) begin
          for (int l = 0; l < WE; l++)
            if (bus.req_be[l]) shadow[bus.req_addr][l*CH +: CH] = bus.req_data[l*CH +: CH];
        end else begin
          exp_q.push_back(shadow[bus.req_addr]);
          exp_t.push_back(cyc);
        end
      end
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [WE-1:0] be,
                        input logic [DW-1:0] d, output int t);
    logic got;
    got = 1'b0;
    t = -1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_data  = d;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        t = cyc;
      end
    end
    chk("req_timeout", DW'(got), DW'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int t, output logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    t = -1;
    d = '0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1;
        t = cyc;
        d = bus.resp_data;
      end
    end
    chk("resp_timeout", DW'(got), DW'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    rand_mode = 1'b0;
    rr_manual = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("drain_empty", DW'(exp_q.size()), DW'(0));
  endtask

  int            t0, t1, n;
  int            ts [8];
  logic [DW-1:0] rd;
  logic          stop;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cnt_after_reset", DW'(dut.cnt), DW'(0));
    chk("ready_after_reset", DW'(bus.req_ready), DW'(1));
    chk("rv_after_reset", DW'(bus.resp_valid), DW'(0));
    @(posedge clk); #1;

    for (int i = 0; i < (1 << AW); i++)
      do_req(1'b1, AW'(i), 4'hF, DW'(i) * 32'h01010101, t0);

    // write then read back-to-back, full lanes
    do_req(1'b1, 4'd5, 4'hF, 32'hDEADBEEF, t0);
    do_req(1'b0, 4'd5, 4'h0, 32'h0, t0);
    wait_resp(t1, rd);
    chk("read_latency", DW'(t1 - t0), DW'(LAT + 1));
    chk("raw_full", rd, 32'hDEADBEEF);

    // partial lane merge
    do_req(1'b1, 4'd5, 4'b0101, 32'h11223344, t0);
    do_req(1'b0, 4'd5, 4'h0, 32'h0, t0);
    wait_resp(t1, rd);
    chk("raw_partial", rd, 32'hDE22BE44);
    drain();

    // back-to-back reads at full throughput
    do_req(1'b1, 4'd5, 4'hF, 32'h05050505, t0);
    for (int i = 0; i < 8; i++) do_req(1'b0, AW'(i), 4'h0, 32'h0, ts[i]);
    for (int i = 1; i < 8; i++) chk("b2b_gap", DW'(ts[i] - ts[0]), DW'(i));
    drain();

    // backpressure: credit exhausts after RESP_DEPTH reads
    rr_manual = 1'b0;
    n = 0;
    stop = 1'b0;
    bus.req_write = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = AW'($urandom_range(0, 15));
    for (int k = 0; k < 20 && !stop; k++) begin
      @(negedge clk);
      if (!bus.req_ready) stop = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
        bus.req_addr = AW'($urandom_range(0, 15));
      end
    end
    chk("bp_accepted", DW'(n), DW'(RESP_DEPTH));
    repeat (LAT + 2) @(posedge clk);
    #1;
    rr_manual = 1'b1;
    @(negedge clk);
    chk("bp_ready_same_cycle", DW'(bus.req_ready), DW'(0));
    @(posedge clk); #1;
    rr_manual = 1'b0;
    @(negedge clk);
    chk("bp_ready_next_cycle", DW'(bus.req_ready), DW'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain();

    // zero-enable write leaves memory untouched
    do_req(1'b1, 4'd3, 4'h0, DW'($urandom), t0);
    do_req(1'b0, 4'd3, 4'h0, 32'h0, t0);
    wait_resp(t1, rd);
    chk("zero_be_write", rd, 32'h03030303);
    drain();

    // reset with reads in flight and responses queued
    rr_manual = 1'b0;
    for (int i = 0; i < 4; i++) do_req(1'b0, AW'(i + 8), 4'h0, 32'h0, t0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cnt_mid_reset", DW'(dut.cnt), DW'(0));
    chk("rv_mid_reset", DW'(bus.resp_valid), DW'(0));
    chk("ready_mid_reset", DW'(bus.req_ready), DW'(1));
    @(posedge clk); #1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    rr_manual = 1'b1;
    do_req(1'b0, 4'd2, 4'h0, 32'h0, t0);
    wait_resp(t1, rd);
    chk("read_after_reset", rd, 32'h02020202);
    drain();

    // randomized mixed traffic with random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_req(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)),
             WE'($urandom_range(0, 15)), DW'($urandom), t0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
